alu_cmd_parser: RTL
===================

# alu_cmd_parser

Byte-stream command parser directly upstream of the ALU. It accepts bytes from the UART receiver over a valid/ready stream and assembles each frame into one ALU command: opcode, operand A and operand B. It presents that command on a registered valid/ready output and flags malformed or stalled frames. All ALU operations on the board enter through this block.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be a multiple of 8 and at least 8. `BYTES = WIDTH/8`.
- `TIMEOUT_CYCLES`, default 12000: maximum idle cycles between bytes inside a frame (1 ms at 12 MHz). Must be at least 2.
- `clk_i` input 1: the single clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `rx_data_i` input 8: incoming byte.
- `rx_valid_i` input 1: `rx_data_i` is valid.
- `rx_ready_o` output 1: parser accepts a byte this cycle. Registered.
- `cmd_op_o` output 3: ALU opcode.
- `cmd_a_o` output WIDTH: operand A.
- `cmd_b_o` output WIDTH: operand B.
- `cmd_valid_o` output 1: command available.
- `cmd_ready_i` input 1: ALU accepts the command.
- `err_opcode_o` output 1: one-cycle pulse, illegal opcode byte received.
- `err_timeout_o` output 1: one-cycle pulse, frame abandoned on timeout.

## Operation
- Frame layout: 1 opcode byte, then BYTES bytes of A, then BYTES bytes of B. Operands are little-endian: the first operand byte goes to bits [7:0].
- An opcode byte is legal when `rx_data_i[7:3] == 0`. Encoding of `rx_data_i[2:0]`: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra. `cmd_op_o` takes `rx_data_i[2:0]`.
- A byte is accepted on any cycle with `rx_valid_i && rx_ready_o`.
- States:
  - IDLE: wait for opcode. On a legal byte, latch the opcode, clear the byte counter, go to OP_A. On an illegal byte, pulse `err_opcode_o`, clear the counter, go to DROP.
  - OP_A: shift bytes into A. After the BYTES-th byte, clear the counter and go to OP_B.
  - OP_B: shift bytes into B. After the BYTES-th byte, go to HOLD.
  - HOLD: `cmd_valid_o`=1 and `rx_ready_o`=0. On `cmd_valid_o && cmd_ready_i`, go to IDLE.
  - DROP: accept and discard 2*BYTES bytes, then go to IDLE. This keeps the parser aligned to frame boundaries.
- Timeout counter:
  - Active only in OP_A, OP_B and DROP. Cleared on every accepted byte and on every state entry.
  - When it reaches TIMEOUT_CYCLES-1 with no byte accepted that cycle, go to IDLE and discard partial operands.
  - The abandon pulses `err_timeout_o` when leaving OP_A or OP_B. It is silent when leaving DROP.
- The byte counter is `$clog2(BYTES+1)` bits wide. The timeout counter is `$clog2(TIMEOUT_CYCLES)` bits wide. Neither wraps: both are cleared before reaching their limits.
- `cmd_op_o`, `cmd_a_o` and `cmd_b_o` change only while in OP_A/OP_B (shift) or IDLE (opcode latch). They are stable throughout HOLD.

## Timing
- Reset, with `rst_i` high on a clock edge: state IDLE, `rx_ready_o`=0, `cmd_valid_o`=0, `cmd_op_o`=0, `cmd_a_o`=0, `cmd_b_o`=0, both error pulses 0, both counters 0. Reset mid-frame or in HOLD discards everything with no error pulse.
- `rx_ready_o` is 1 from the first cycle after reset is released. It is computed from the next state: it is 0 on exactly the cycles where the state is HOLD.
- Latency: `cmd_valid_o` rises on the cycle after the edge that accepts the last B byte. A full frame at one byte per cycle gives `cmd_valid_o` high 1+2*BYTES cycles after the opcode is accepted.
- `cmd_valid_o` holds while `cmd_ready_i` is low, with unchanging data. After the handshake edge, `cmd_valid_o`=0 and `rx_ready_o`=1 on the next cycle. There is no bubble beyond that.
- Error pulses are registered. Each is high for exactly the one cycle after the triggering edge.
- Timeout and byte arrival on the same cycle: the byte wins and the counter clears.

## Test plan
- **Basic add, WIDTH=32:** bytes 00, 05 00 00 00, 07 00 00 00 at 1 byte/cycle -> `cmd_valid_o`=1 9 cycles after the opcode, `cmd_op_o`=0, A=0x5, B=0x7.
- **Little-endian and backpressure:** opcode 04, A bytes 78 56 34 12, B bytes EF BE AD DE, `cmd_ready_i` low for 5 cycles -> A=0x12345678, B=0xDEADBEEF held stable, `rx_ready_o`=0 throughout; one handshake, then `rx_ready_o`=1.
- **Illegal opcode:** byte 0x2A -> `err_opcode_o` 1-cycle pulse; the next 8 bytes are swallowed; the following frame 01 / 0A 00 00 00 / 03 00 00 00 yields op=1, A=10, B=3.
- **Timeout, TIMEOUT_CYCLES=16:** opcode 02 plus 2 A bytes, then 16 idle cycles -> `err_timeout_o` pulse, no `cmd_valid_o`; the next full frame parses correctly.
- **Timeout boundary:** opcode, then a byte arriving on exactly the 15th idle cycle -> no timeout, parsing continues.
- **Reset mid-frame:** `rst_i` high for 1 cycle after 4 bytes -> all outputs zero; a fresh frame parses correctly with no error pulse.

Source files
------------

// File: rtl/alu_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_parser
// Brief    : Assembles opcode + little-endian A/B operand bytes from a byte
//            stream into one registered ALU command, flagging bad/stalled frames.
// Revision : 1.0
// ============================================================================
module alu_cmd_parser #(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 12000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [7:0]       rx_data_i,
   input  logic             rx_valid_i,
   output logic             rx_ready_o,
   output logic [2:0]       cmd_op_o,
   output logic [WIDTH-1:0] cmd_a_o,
   output logic [WIDTH-1:0] cmd_b_o,
   output logic             cmd_valid_o,
   input  logic             cmd_ready_i,
   output logic             err_opcode_o,
   output logic             err_timeout_o
);

   localparam int BYTES = WIDTH / 8;
   localparam int CNT_W = $clog2(BYTES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_OP_A = 3'd1,
      ST_OP_B = 3'd2,
      ST_HOLD = 3'd3,
      ST_DROP = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             drop_half_q, drop_half_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             rx_ready_q, rx_ready_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic             err_op_q, err_op_d;
   logic             err_to_q, err_to_d;

   logic             accept;
   logic             to_expired;
   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] b_shift;

   assign accept     = rx_valid_i && rx_ready_q;
   assign to_expired = (to_cnt_q == TO_LAST) && !accept;

   // New bytes enter at the top so the first byte ends up in bits [7:0].
   generate
      if (BYTES == 1) begin : g_single_byte
         assign a_shift = rx_data_i;
         assign b_shift = rx_data_i;
      end else begin : g_multi_byte
         assign a_shift = {rx_data_i, a_q[WIDTH-1:8]};
         assign b_shift = {rx_data_i, b_q[WIDTH-1:8]};
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      to_cnt_d    = '0;
      drop_half_d = drop_half_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      err_op_d    = 1'b0;
      err_to_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               byte_cnt_d = '0;
               if (rx_data_i[7:3] == 5'd0) begin
                  op_d    = rx_data_i[2:0];
                  state_d = ST_OP_A;
               end else begin
                  err_op_d    = 1'b1;
                  drop_half_d = 1'b0;
                  state_d     = ST_DROP;
               end
            end
         end
         ST_OP_A: begin
            if (accept) begin
               a_d = a_shift;
               if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_d = '0;
                  state_d    = ST_OP_B;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end else if (to_expired) begin
               err_to_d   = 1'b1;
               byte_cnt_d = '0;
               state_d    = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ST_OP_B: begin
            if (accept) begin
               b_d = b_shift;
               if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_d = '0;
                  state_d    = ST_HOLD;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end else if (to_expired) begin
               err_to_d   = 1'b1;
               byte_cnt_d = '0;
               state_d    = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (cmd_valid_q && cmd_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            // Two passes of BYTES bytes keep the counter within its width.
            if (accept) begin
               if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_d = '0;
                  if (drop_half_q) begin
                     drop_half_d = 1'b0;
                     state_d     = ST_IDLE;
                  end else begin
                     drop_half_d = 1'b1;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end else if (to_expired) begin
               byte_cnt_d  = '0;
               drop_half_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         default: begin
            byte_cnt_d  = '0;
            drop_half_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase

      rx_ready_d  = (state_d != ST_HOLD);
      cmd_valid_d = (state_d == ST_HOLD);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         byte_cnt_q  <= '0;
         to_cnt_q    <= '0;
         drop_half_q <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rx_ready_q  <= 1'b0;
         cmd_valid_q <= 1'b0;
         err_op_q    <= 1'b0;
         err_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         to_cnt_q    <= to_cnt_d;
         drop_half_q <= drop_half_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rx_ready_q  <= rx_ready_d;
         cmd_valid_q <= cmd_valid_d;
         err_op_q    <= err_op_d;
         err_to_q    <= err_to_d;
      end
   end

   assign rx_ready_o    = rx_ready_q;
   assign cmd_op_o      = op_q;
   assign cmd_a_o       = a_q;
   assign cmd_b_o       = b_q;
   assign cmd_valid_o   = cmd_valid_q;
   assign err_opcode_o  = err_op_q;
   assign err_timeout_o = err_to_q;

endmodule
`default_nettype wire
